arbitro_escrita_reg: RTL and testbench
======================================

ARBITRO_ESCRITA_REG -- requirements
Module: arbitro_escrita_reg

Interface
REQ-001 Parameter PRIO_INICIAL, default 0, SHALL select the requester favoured after reset: 0 = A, 1 = B.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 ValidA  input  1  requester A (ALU writeback) offers a write.
REQ-005 RegA  input  5  requester A destination register.
REQ-006 DataA  input  32  requester A write data.
REQ-007 ReadyA  output  1  requester A accept; a transfer occurs on an edge where ValidA and ReadyA are both 1.
REQ-008 ValidB, RegB, DataB, ReadyB SHALL be identical to REQ-004..007 for requester B (load writeback).
REQ-009 RegWrite  output  1  registered write enable to the register bank.
REQ-010 WriteRegister  output  5  registered destination to the register bank.
REQ-011 WriteData  output  32  registered data to the register bank.
REQ-012 Pending  output  32  bit r = 1 while a write to register r is accepted but not yet committed by the bank.

Function
REQ-013 Each requester SHALL own a one-entry hold buffer (valid bit, 5-bit register, 32-bit data).
REQ-014 A transfer with destination register 0 SHALL be accepted per normal handshake and discarded: no buffer load, no RegWrite, no Pending effect.
REQ-015 ReadyX SHALL equal (hold X empty) OR (hold X granted this cycle); ReadyX SHALL NOT depend on ValidX.
REQ-016 Each cycle the arbiter SHALL grant exactly one non-empty hold buffer, or none if both are empty.
REQ-017 If only one hold is valid it SHALL be granted; if both are valid, the requester selected by the priority pointer SHALL be granted.
REQ-018 After every grant, the pointer SHALL favour the non-granted requester; with no grant, the pointer SHALL hold.
REQ-019 On the edge ending a granted cycle, RegWrite SHALL become 1 and WriteRegister/WriteData SHALL take the granted entry.
REQ-020 On the same edge, the granted hold SHALL clear, unless it reloads from a simultaneous transfer.
REQ-021 With no grant, RegWrite SHALL become 0; WriteRegister/WriteData SHALL hold their previous values.
REQ-022 Latency: transfer at edge E0 into an uncontended empty hold -> RegWrite=1 during the cycle after E1 -> bank commits at E2.
REQ-023 Throughput: sustained 1 write/cycle total; one requester alone SHALL sustain 1 write/cycle.
REQ-024 Pending[r] SHALL be 1 if either hold holds r, or if RegWrite=1 with WriteRegister=r; Pending[0] SHALL be 0 always.
REQ-025 Both holds targeting the same register SHALL commit in grant order; the later grant SHALL be the final value.
REQ-026 Order within one requester SHALL be preserved; no accepted write SHALL be lost or duplicated.

Reset
REQ-027 While rst_n=0: RegWrite=0, WriteRegister=0, WriteData=0, both holds empty, Pending=0, ReadyA=ReadyB=0, pointer=PRIO_INICIAL.
REQ-028 Reset assertion mid-operation SHALL discard buffered and in-flight writes immediately, with no bank write.
REQ-029 From the first clk edge after rst_n rises, ReadyA=ReadyB=1.

Verification
REQ-030 A alone: A writes r8=5 -> RegWrite=1, WriteRegister=8, WriteData=5 two edges later; Pending[8]=1 until commit.
REQ-031 A and B offer together, PRIO_INICIAL=0: A r9=3, B r10=7 -> commits r9 then r10 on consecutive cycles; ReadyB=0 for one cycle.
REQ-032 A and B both valid continuously for 8 cycles -> grants strictly alternate A,B,A,B...; output rate 1/cycle; no loss.
REQ-033 Write to r0 from A, data FFFFFFFF -> accepted, RegWrite stays 0, Pending stays 0.
REQ-034 A r8=1 and B r8=2 offered together, PRIO_INICIAL=1 -> B granted first, then A; final committed r8=1.
REQ-035 rst_n pulsed low while both holds are full -> all outputs 0 immediately; no RegWrite afterward until new transfers occur.

Source files
------------

// File: rtl/arbitro_escrita_reg.sv
// Write-port arbiter: two writeback requesters (A = ALU, B = load) share one
// register-bank write port through one-entry hold buffers and a round-robin pointer.
module arbitro_escrita_reg #(
  parameter int PRIO_INICIAL = 0,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidA,
  input  logic [4:0]        RegA,
  input  logic [DATA_W-1:0] DataA,
  output logic              ReadyA,
  input  logic              ValidB,
  input  logic [4:0]        RegB,
  input  logic [DATA_W-1:0] DataB,
  output logic              ReadyB,
  output logic              RegWrite,
  output logic [4:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       Pending
);

  logic              run_p0;
  logic              hold_a_vld_p0;
  logic [4:0]        hold_a_reg_p0;
  logic [DATA_W-1:0] hold_a_data_p0;
  logic              hold_b_vld_p0;
  logic [4:0]        hold_b_reg_p0;
  logic [DATA_W-1:0] hold_b_data_p0;
  logic              prio_b_p0;
  logic              grant_a;
  logic              grant_b;
  logic              load_a;
  logic              load_b;

  always_comb begin
    grant_a = hold_a_vld_p0 && (!hold_b_vld_p0 || !prio_b_p0);
    grant_b = hold_b_vld_p0 && (!hold_a_vld_p0 || prio_b_p0);
    // run_p0 keeps both ports closed until the first edge after reset release
    ReadyA  = run_p0 && (!hold_a_vld_p0 || grant_a);
    ReadyB  = run_p0 && (!hold_b_vld_p0 || grant_b);
    load_a  = ValidA && ReadyA && (RegA != 5'd0);
    load_b  = ValidB && ReadyB && (RegB != 5'd0);
  end

  // Stage p0: hold buffers, priority pointer; stage p1: bank write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p0        <= 1'b0;
      hold_a_vld_p0 <= 1'b0;
      hold_b_vld_p0 <= 1'b0;
      prio_b_p0     <= (PRIO_INICIAL != 0);
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= '0;
    end else begin
      run_p0 <= 1'b1;
      if (load_a)       hold_a_vld_p0 <= 1'b1;
      else if (grant_a) hold_a_vld_p0 <= 1'b0;
      if (load_b)       hold_b_vld_p0 <= 1'b1;
      else if (grant_b) hold_b_vld_p0 <= 1'b0;
      if (grant_a)      prio_b_p0 <= 1'b1;
      else if (grant_b) prio_b_p0 <= 1'b0;
      RegWrite <= grant_a || grant_b;
      if (grant_a) begin
        WriteRegister <= hold_a_reg_p0;
        WriteData     <= hold_a_data_p0;
      end else if (grant_b) begin
        WriteRegister <= hold_b_reg_p0;
        WriteData     <= hold_b_data_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_a) begin
      hold_a_reg_p0  <= RegA;
      hold_a_data_p0 <= DataA;
    end
    if (load_b) begin
      hold_b_reg_p0  <= RegB;
      hold_b_data_p0 <= DataB;
    end
  end

  always_comb begin
    Pending = '0;
    if (hold_a_vld_p0) Pending[hold_a_reg_p0] = 1'b1;
    if (hold_b_vld_p0) Pending[hold_b_reg_p0] = 1'b1;
    if (RegWrite)      Pending[WriteRegister] = 1'b1;
    Pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// Bench for arbitro_escrita_reg: two instances (PRIO_INICIAL 0 and 1) on shared
// stimulus, compared every cycle against a rule-level model, plus directed scenarios.
module tb_arbitro_escrita_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        va, vb;
  logic [4:0]  ra, rb;
  logic [31:0] da, db;

  logic        ready_a [2];
  logic        ready_b [2];
  logic        rw      [2];
  logic [4:0]  wr      [2];
  logic [31:0] wd      [2];
  logic [31:0] pend    [2];

  int total = 0;
  int bad   = 0;

  // model state, index 0 = PRIO_INICIAL 0 instance, 1 = PRIO_INICIAL 1 instance
  bit          m_run [2];
  int          m_ptr [2];
  bit          m_hv  [2][2];
  logic [4:0]  m_hr  [2][2];
  logic [31:0] m_hd  [2][2];
  bit          m_rw  [2];
  logic [4:0]  m_wr  [2];
  logic [31:0] m_wd  [2];
  logic [31:0] m_mem [2][32];

  always #5 clk = ~clk;

  arbitro_escrita_reg #(.PRIO_INICIAL(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ValidA(va), .RegA(ra), .DataA(da), .ReadyA(ready_a[0]),
    .ValidB(vb), .RegB(rb), .DataB(db), .ReadyB(ready_b[0]),
    .RegWrite(rw[0]), .WriteRegister(wr[0]), .WriteData(wd[0]), .Pending(pend[0])
  );

  arbitro_escrita_reg #(.PRIO_INICIAL(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ValidA(va), .RegA(ra), .DataA(da), .ReadyA(ready_a[1]),
    .ValidB(vb), .RegB(rb), .DataB(db), .ReadyB(ready_b[1]),
    .RegWrite(rw[1]), .WriteRegister(wr[1]), .WriteData(wd[1]), .Pending(pend[1])
  );

  function automatic int mgrant(int i);
    if (m_hv[i][0] && m_hv[i][1]) return m_ptr[i];
    if (m_hv[i][0]) return 0;
    if (m_hv[i][1]) return 1;
    return -1;
  endfunction

  function automatic bit mready(int i, int r);
    return m_run[i] && (!m_hv[i][r] || mgrant(i) == r);
  endfunction

  function automatic logic [31:0] mpend(int i);
    logic [31:0] p;
    p = '0;
    for (int r = 0; r < 2; r++) if (m_hv[i][r]) p[m_hr[i][r]] = 1'b1;
    if (m_rw[i]) p[m_wr[i]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ReadyA[%0d]", i), 32'(ready_a[i]), 32'(mready(i, 0)));
      chk($sformatf("ReadyB[%0d]", i), 32'(ready_b[i]), 32'(mready(i, 1)));
      chk($sformatf("RegWrite[%0d]", i), 32'(rw[i]), 32'(m_rw[i]));
      chk($sformatf("WriteRegister[%0d]", i), 32'(wr[i]), 32'(m_wr[i]));
      chk($sformatf("WriteData[%0d]", i), wd[i], m_wd[i]);
      chk($sformatf("Pending[%0d]", i), pend[i], mpend(i));
    end
  endtask

  task automatic model_update();
    bit          v  [2];
    logic [4:0]  rg [2];
    logic [31:0] dt [2];
    bit          rdy[2];
    int          g;
    v[0] = va; rg[0] = ra; dt[0] = da;
    v[1] = vb; rg[1] = rb; dt[1] = db;
    for (int i = 0; i < 2; i++) begin
      g = mgrant(i);
      rdy[0] = mready(i, 0);
      rdy[1] = mready(i, 1);
      if (g >= 0) begin
        m_rw[i] = 1'b1;
        m_wr[i] = m_hr[i][g];
        m_wd[i] = m_hd[i][g];
        m_mem[i][m_hr[i][g]] = m_hd[i][g];
        m_ptr[i] = 1 - g;
        m_hv[i][g] = 1'b0;
      end else begin
        m_rw[i] = 1'b0;
      end
      for (int r = 0; r < 2; r++) begin
        if (v[r] && rdy[r] && rg[r] != 5'd0) begin
          m_hv[i][r] = 1'b1;
          m_hr[i][r] = rg[r];
          m_hd[i][r] = dt[r];
        end
      end
      m_run[i] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0;
      m_ptr[i] = i;
      m_hv[i][0] = 1'b0;
      m_hv[i][1] = 1'b0;
      m_rw[i] = 1'b0;
      m_wr[i] = 5'd0;
      m_wd[i] = 32'd0;
    end
  endtask

  task automatic drive(input logic a_v, input logic [4:0] a_r, input logic [31:0] a_d,
                       input logic b_v, input logic [4:0] b_r, input logic [31:0] b_d);
    va = a_v; ra = a_r; da = a_d;
    vb = b_v; rb = b_r; db = b_d;
  endtask

  // called at a falling edge; returns at the next falling edge after checking
  task automatic step(input logic a_v, input logic [4:0] a_r, input logic [31:0] a_d,
                      input logic b_v, input logic [4:0] b_r, input logic [31:0] b_d);
    drive(a_v, a_r, a_d, b_v, b_r, b_d);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst RegWrite[%0d]", i), 32'(rw[i]), 32'd0);
      chk($sformatf("rst WriteRegister[%0d]", i), 32'(wr[i]), 32'd0);
      chk($sformatf("rst WriteData[%0d]", i), wd[i], 32'd0);
      chk($sformatf("rst Pending[%0d]", i), pend[i], 32'd0);
      chk($sformatf("rst ReadyA[%0d]", i), 32'(ready_a[i]), 32'd0);
      chk($sformatf("rst ReadyB[%0d]", i), 32'(ready_b[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) m_mem[i][r] = 32'd0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("post-reset ReadyA", 32'(ready_a[0]), 32'd1);
    chk("post-reset ReadyB", 32'(ready_b[1]), 32'd1);

    // A alone: r8=5
    step(1'b1, 5'd8, 32'd5, 1'b0, 5'd0, 32'd0);
    chk("solo Pending8 held", 32'(pend[0][8]), 32'd1);
    chk("solo RegWrite E0", 32'(rw[0]), 32'd0);
    idle();
    chk("solo RegWrite E1", 32'(rw[0]), 32'd1);
    chk("solo WriteRegister", 32'(wr[0]), 32'd8);
    chk("solo WriteData", wd[0], 32'd5);
    chk("solo Pending8 out", 32'(pend[0][8]), 32'd1);
    idle();
    chk("solo RegWrite done", 32'(rw[0]), 32'd0);
    chk("solo Pending8 done", 32'(pend[0][8]), 32'd0);

    // A r9=3 and B r10=7 together
    do_reset();
    step(1'b1, 5'd9, 32'd3, 1'b1, 5'd10, 32'd7);
    chk("both ReadyA p0", 32'(ready_a[0]), 32'd1);
    chk("both ReadyB p0", 32'(ready_b[0]), 32'd0);
    chk("both ReadyA p1", 32'(ready_a[1]), 32'd0);
    idle();
    chk("both first reg", 32'(wr[0]), 32'd9);
    chk("both first data", wd[0], 32'd3);
    idle();
    chk("both second we", 32'(rw[0]), 32'd1);
    chk("both second reg", 32'(wr[0]), 32'd10);
    chk("both second data", wd[0], 32'd7);
    idle();

    // continuous contention: strict alternation, one write per cycle
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 5'd3, 32'(k), 1'b1, 5'd4, 32'(100 + k));
      if (k >= 2) begin
        chk($sformatf("alt we k=%0d", k), 32'(rw[0]), 32'd1);
        chk($sformatf("alt reg k=%0d", k), 32'(wr[0]), (k % 2 == 0) ? 32'd3 : 32'd4);
      end
    end
    repeat (3) idle();

    // write to r0 is swallowed
    do_reset();
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    chk("r0 Pending", pend[0], 32'd0);
    chk("r0 ReadyA", 32'(ready_a[0]), 32'd1);
    idle();
    chk("r0 RegWrite", 32'(rw[0]), 32'd0);
    idle();
    chk("r0 RegWrite late", 32'(rw[0]), 32'd0);

    // same register from both sides; PRIO_INICIAL=1 grants B first
    do_reset();
    step(1'b1, 5'd8, 32'd1, 1'b1, 5'd8, 32'd2);
    idle();
    chk("same-reg first data p1", wd[1], 32'd2);
    idle();
    chk("same-reg second data p1", wd[1], 32'd1);
    chk("same-reg second reg p1", 32'(wr[1]), 32'd8);
    idle();
    chk("same-reg final model p1", m_mem[1][8], 32'd1);
    chk("same-reg final model p0", m_mem[0][8], 32'd2);

    // reset while both holds are full
    step(1'b1, 5'd5, 32'd11, 1'b1, 5'd6, 32'd22);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      chk($sformatf("after-rst we0 k=%0d", k), 32'(rw[0]), 32'd0);
      chk($sformatf("after-rst we1 k=%0d", k), 32'(rw[1]), 32'd0);
    end

    // random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
    end
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
